// File: rtl/des_pkg.sv
// Shared DES definitions: permutation tables, rotation schedule, sequencer
// state encodings and small helpers. The round datapath imports this as well.
//
// Bit numbering: DES numbers bits from 1 at the MSB. Vectors here are declared
// descending, so DES bit n of a W-bit vector lives at index W-n.
package des_pkg;

    // Sequencer states.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ROUND = 1'b1
    } state_e;

    localparam int KEY_W    = 64;
    localparam int CD_W     = 56;
    localparam int HALF_W   = 28;
    localparam int SUBKEY_W = 48;
    localparam int ROUNDS   = 16;

    // PC-1: 64-bit key -> 56-bit C||D, entries are DES bit numbers (1-based).
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    // PC-2: 56-bit C||D -> 48-bit subkey, entries are DES bit numbers (1-based).
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Left-rotation amount applied before round r, stored at index r-1.
    localparam logic [1:0] SHIFTS [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Apply PC-1 to a key; parity bits (every 8th DES bit) are dropped.
    function automatic logic [CD_W-1:0] pc1_perm(input logic [KEY_W-1:0] k);
        logic [CD_W-1:0] r;
        r = '0;
        for (int i = 0; i < CD_W; i++) begin
            r[CD_W-1-i] = k[KEY_W-PC1[i]];
        end
        return r;
    endfunction

    // Rotate a 28-bit half left by 1 or 2 (anything other than 1 means 2).
    function automatic logic [HALF_W-1:0] rotl28(input logic [HALF_W-1:0] x,
                                                 input logic [1:0] n);
        logic [HALF_W-1:0] r;
        if (n == 2'd1) begin
            r = {x[HALF_W-2:0], x[HALF_W-1]};
        end else begin
            r = {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]};
        end
        return r;
    endfunction

    // Rotate a 28-bit half right by 1 or 2 (anything other than 1 means 2).
    function automatic logic [HALF_W-1:0] rotr28(input logic [HALF_W-1:0] x,
                                                 input logic [1:0] n);
        logic [HALF_W-1:0] r;
        if (n == 2'd1) begin
            r = {x[0], x[HALF_W-1:1]};
        end else begin
            r = {x[1:0], x[HALF_W-1:2]};
        end
        return r;
    endfunction

    // True when every key byte has an odd number of ones.
    function automatic logic key_parity_ok(input logic [KEY_W-1:0] k);
        logic ok;
        ok = 1'b1;
        for (int b = 0; b < 8; b++) begin
            if (^k[8*b +: 8] == 1'b0) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/des_pc2.sv
// Combinational PC-2: selects the 48 subkey bits out of the 56-bit C||D state.
module des_pc2
    import des_pkg::*;
(
    input  logic [CD_W-1:0]     cd,
    output logic [SUBKEY_W-1:0] subkey
);

    // Pure wiring permutation, one output bit per table entry.
    always_comb begin
        subkey = '0;
        for (int i = 0; i < SUBKEY_W; i++) begin
            subkey[SUBKEY_W-1-i] = cd[CD_W-PC2[i]];
        end
    end

endmodule

// File: rtl/des_key_sched_ctrl.sv
// Iterative DES key-schedule sequencer. Latches PC-1 of the key on accept and
// then walks the C/D rotations, presenting one 48-bit subkey per handshake:
// K1..K16 for encryption, K16..K1 for decryption.
//
// Subkey interface: subkey_valid is high for the whole ROUND state. A transfer
// happens on a rising edge where subkey_valid && subkey_ready; until then
// subkey and round_idx hold stable, and valid never drops except on abort or
// reset. round_idx is the issue slot, not the DES round number.
//
// key and subkey are MSB-first: DES bit 1 is key[63] and subkey[47].
module des_key_sched_ctrl
    import des_pkg::*;
#(
    parameter bit PARITY_CHECK = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                mode,
    input  logic [KEY_W-1:0]    key,
    input  logic                abort,
    output logic                busy,
    output logic                subkey_valid,
    input  logic                subkey_ready,
    output logic [SUBKEY_W-1:0] subkey,
    output logic [3:0]          round_idx,
    output logic                last_round,
    output logic                done,
    output logic                key_err,
    output state_e              dbg_state
);

    state_e                state_q, state_d;
    logic [HALF_W-1:0]     c_q, c_d;
    logic [HALF_W-1:0]     dh_q, dh_d;
    logic [3:0]            idx_q, idx_d;
    logic                  mode_q, mode_d;
    logic                  done_q, done_d;
    logic                  key_err_q, key_err_d;

    logic                  in_round;
    logic                  handshake;
    logic                  key_ok;
    logic [CD_W-1:0]       pc1_key;
    logic [1:0]            enc_shift;
    logic [1:0]            dec_shift;

    assign in_round  = (state_q == ST_ROUND);
    assign handshake = in_round && subkey_ready;
    assign key_ok    = !PARITY_CHECK || key_parity_ok(key);
    assign pc1_key   = pc1_perm(key);

    // Slot i moves to slot i+1: encrypt needs the shift of round i+2, decrypt
    // undoes the shift of round 16-i. Only used while idx_q < 15.
    assign enc_shift = SHIFTS[idx_q + 4'd1];
    assign dec_shift = SHIFTS[4'd15 - idx_q];

    // Next-state logic: accept, per-handshake rotation, completion and abort.
    always_comb begin
        state_d   = state_q;
        c_d       = c_q;
        dh_d      = dh_q;
        idx_d     = idx_q;
        mode_d    = mode_q;
        done_d    = 1'b0;
        key_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (key_ok) begin
                        state_d = ST_ROUND;
                        mode_d  = mode;
                        idx_d   = 4'd0;
                        if (mode) begin
                            // Total shift over 16 rounds is 28, so C16||D16 == C0||D0.
                            c_d  = pc1_key[CD_W-1:HALF_W];
                            dh_d = pc1_key[HALF_W-1:0];
                        end else begin
                            c_d  = rotl28(pc1_key[CD_W-1:HALF_W], 2'd1);
                            dh_d = rotl28(pc1_key[HALF_W-1:0], 2'd1);
                        end
                    end else begin
                        key_err_d = 1'b1;
                    end
                end
            end
            ST_ROUND: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (handshake) begin
                    if (idx_q == 4'd15) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                        if (mode_q) begin
                            c_d  = rotr28(c_q, dec_shift);
                            dh_d = rotr28(dh_q, dec_shift);
                        end else begin
                            c_d  = rotl28(c_q, enc_shift);
                            dh_d = rotl28(dh_q, enc_shift);
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, C/D registers and registered status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            c_q       <= '0;
            dh_q      <= '0;
            idx_q     <= 4'd0;
            mode_q    <= 1'b0;
            done_q    <= 1'b0;
            key_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            c_q       <= c_d;
            dh_q      <= dh_d;
            idx_q     <= idx_d;
            mode_q    <= mode_d;
            done_q    <= done_d;
            key_err_q <= key_err_d;
        end
    end

    // Subkey depends only on the registered C||D, never on key/start.
    des_pc2 u_pc2 (
        .cd     ({c_q, dh_q}),
        .subkey (subkey)
    );

    assign busy         = in_round;
    assign subkey_valid = in_round;
    assign round_idx    = idx_q;
    assign last_round   = in_round && (idx_q == 4'd15);
    assign done         = done_q;
    assign key_err      = key_err_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// Directed bench for des_key_sched_ctrl using the textbook DES key
// 0x133457799BBCDFF1, whose sixteen subkeys are tabulated below.
module tb_des_key_sched_ctrl;
    import des_pkg::*;

    localparam logic [63:0] KEY_A   = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_B   = 64'h0E329232EA6D0D73;
    localparam logic [63:0] KEY_BAD = 64'h133457799BBCDFF0;

    // K1..K16 for KEY_A.
    localparam logic [47:0] ENC_K [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT (PARITY_CHECK = 0) ----------------
    logic        start, mode, abort, subkey_ready;
    logic [63:0] key;
    logic        busy, subkey_valid, last_round, done, key_err;
    logic [47:0] subkey;
    logic [3:0]  round_idx;
    state_e      dbg_state;

    des_key_sched_ctrl #(.PARITY_CHECK(1'b0)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .mode         (mode),
        .key          (key),
        .abort        (abort),
        .busy         (busy),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .subkey       (subkey),
        .round_idx    (round_idx),
        .last_round   (last_round),
        .done         (done),
        .key_err      (key_err),
        .dbg_state    (dbg_state)
    );

    // ---------------- DUT (PARITY_CHECK = 1) ----------------
    logic        p_start, p_mode, p_abort, p_ready;
    logic [63:0] p_key;
    logic        p_busy, p_valid, p_last, p_done, p_key_err;
    logic [47:0] p_subkey;
    logic [3:0]  p_idx;
    state_e      p_state;

    des_key_sched_ctrl #(.PARITY_CHECK(1'b1)) dut_p (
        .clk          (clk),
        .rst          (rst),
        .start        (p_start),
        .mode         (p_mode),
        .key          (p_key),
        .abort        (p_abort),
        .busy         (p_busy),
        .subkey_valid (p_valid),
        .subkey_ready (p_ready),
        .subkey       (p_subkey),
        .round_idx    (p_idx),
        .last_round   (p_last),
        .done         (p_done),
        .key_err      (p_key_err),
        .dbg_state    (p_state)
    );

    // ---------------- scoreboard ----------------
    logic [47:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic load_exp(input logic m);
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(m ? ENC_K[15-i] : ENC_K[i]);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Pulses start for one edge; returns at the negedge where slot 0 should show.
    task automatic start_sched(input logic m, input logic [63:0] k);
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        key   = k;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Consumes the running schedule against exp_q. Returns at the negedge where
    // done is high; cycles counts from the accept edge.
    task automatic drain(input int ready_pct, input bit mid_start, output int cycles);
        int          hs;
        bit          stalled;
        bit          got_done;
        logic [47:0] prev_sub;
        logic [3:0]  prev_idx;
        hs = 0;
        stalled = 1'b0;
        got_done = 1'b0;
        prev_sub = '0;
        prev_idx = '0;
        cycles = 1;
        for (int c = 0; c < 400; c++) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            check("valid_in_round", subkey_valid, 1'b1);
            check("busy_in_round", busy, 1'b1);
            check("last_round", last_round, round_idx == 4'd15);
            if (stalled) begin
                check("stall_subkey", subkey, prev_sub);
                check("stall_idx", round_idx, prev_idx);
            end
            subkey_ready = ($urandom_range(0, 99) < ready_pct);
            start = mid_start && (round_idx == 4'd3 || round_idx == 4'd10);
            if (start) key = KEY_B;
            if (subkey_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_handshake", 1'b1, 1'b0);
                end else begin
                    check("subkey", subkey, exp_q.pop_front());
                end
                check("round_idx", round_idx, hs);
                hs++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
            end
            prev_sub = subkey;
            prev_idx = round_idx;
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        check("done_seen", got_done, 1'b1);
        check("handshakes", hs, 16);
        check("exp_q_empty", exp_q.size(), 0);
        check("done_cycle_valid", subkey_valid, 1'b0);
        check("done_cycle_busy", busy, 1'b0);
    endtask

    task automatic after_done();
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
        check("idle_busy", busy, 1'b0);
    endtask

    // Hands over subkeys with ready high until slot n is presented.
    task automatic run_to_slot(input int n);
        bit hit;
        hit = 1'b0;
        subkey_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (subkey_valid && round_idx == n) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("reached_slot", hit, 1'b1);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int cyc;
        rst = 1'b1;
        start = 1'b0; mode = 1'b0; key = '0; abort = 1'b0; subkey_ready = 1'b0;
        p_start = 1'b0; p_mode = 1'b0; p_key = '0; p_abort = 1'b0; p_ready = 1'b1;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_valid", subkey_valid, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_key_err", key_err, 1'b0);
        check("rst_idx", round_idx, 4'd0);
        check("rst_subkey", subkey, 48'h0);
        check("rst_state", dbg_state, ST_IDLE);
        rst = 1'b0;

        // abort in IDLE does nothing
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("idle_abort_busy", busy, 1'b0);

        // 1: encrypt, ready tied high
        load_exp(1'b0);
        start_sched(1'b0, KEY_A);
        check("t1_state", dbg_state, ST_ROUND);
        check("t1_slot0", subkey, ENC_K[0]);
        drain(100, 1'b0, cyc);
        check("t1_done_cycle", cyc, 17);
        after_done();

        // 2: decrypt, ready tied high
        load_exp(1'b1);
        start_sched(1'b1, KEY_A);
        check("t2_slot0", subkey, ENC_K[15]);
        drain(100, 1'b0, cyc);
        check("t2_done_cycle", cyc, 17);
        after_done();

        // 3: random stalls, both directions
        load_exp(1'b0);
        start_sched(1'b0, KEY_A);
        drain(50, 1'b0, cyc);
        after_done();
        load_exp(1'b1);
        start_sched(1'b1, KEY_A);
        drain(50, 1'b0, cyc);
        after_done();

        // 4: starts mid-run ignored; start in the done cycle is accepted
        load_exp(1'b0);
        start_sched(1'b0, KEY_A);
        drain(100, 1'b1, cyc);
        check("t4_done_cycle", cyc, 17);
        start = 1'b1;
        mode  = 1'b1;
        key   = KEY_A;
        load_exp(1'b1);
        @(negedge clk);
        start = 1'b0;
        check("t4_restart_busy", busy, 1'b1);
        check("t4_restart_done_low", done, 1'b0);
        check("t4_restart_slot0", subkey, ENC_K[15]);
        drain(100, 1'b0, cyc);
        check("t4_b2b_done_cycle", cyc, 17);
        after_done();

        // 5a: abort at slot 7 wins over the handshake
        start_sched(1'b0, KEY_A);
        run_to_slot(7);
        check("t5_slot7", subkey, ENC_K[7]);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t5_abort_valid", subkey_valid, 1'b0);
        check("t5_abort_busy", busy, 1'b0);
        check("t5_abort_no_done", done, 1'b0);
        @(negedge clk);
        check("t5_abort_no_done2", done, 1'b0);
        load_exp(1'b0);
        start_sched(1'b0, KEY_A);
        drain(100, 1'b0, cyc);
        after_done();

        // 5b: async reset at slot 12
        start_sched(1'b0, KEY_A);
        run_to_slot(12);
        check("t5_slot12", subkey, ENC_K[12]);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_valid", subkey_valid, 1'b0);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_idx", round_idx, 4'd0);
        check("t5_rst_subkey", subkey, 48'h0);
        @(negedge clk);
        rst = 1'b0;
        check("t5_rst_no_done", done, 1'b0);
        load_exp(1'b0);
        start_sched(1'b0, KEY_A);
        drain(100, 1'b0, cyc);
        after_done();

        // Without parity checking an even-parity key still runs; parity bits
        // are dropped by PC-1 so K1 matches KEY_A.
        start_sched(1'b0, KEY_BAD);
        check("noparity_busy", busy, 1'b1);
        check("noparity_key_err", key_err, 1'b0);
        check("noparity_k1", subkey, ENC_K[0]);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;

        // 6: PARITY_CHECK=1 rejects a bad key, accepts a good one
        p_start = 1'b1;
        p_key = KEY_BAD;
        @(negedge clk);
        p_start = 1'b0;
        check("t6_key_err", p_key_err, 1'b1);
        check("t6_bad_busy", p_busy, 1'b0);
        check("t6_bad_valid", p_valid, 1'b0);
        @(negedge clk);
        check("t6_key_err_pulse", p_key_err, 1'b0);
        check("t6_bad_busy2", p_busy, 1'b0);
        check("t6_bad_no_done", p_done, 1'b0);
        p_start = 1'b1;
        p_key = KEY_A;
        @(negedge clk);
        p_start = 1'b0;
        check("t6_good_key_err", p_key_err, 1'b0);
        for (int k = 0; k < 16; k++) begin
            check("t6_valid", p_valid, 1'b1);
            check("t6_idx", p_idx, k);
            check("t6_subkey", p_subkey, ENC_K[k]);
            check("t6_last", p_last, k == 15);
            @(negedge clk);
        end
        check("t6_done", p_done, 1'b1);
        check("t6_done_state", p_state, ST_IDLE);

        // ---------------- final report ----------------
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
